// File: rtl/axi_lite_pkg.sv
// Shared constants and helpers for the AXI4-Lite slave register file.
// Response codes, address-LSB derivation and the byte-strobe merge.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic int addr_lsb(input int dw);
    return $clog2(dw / 8);
  endfunction

  // Works on the widest legal bus; callers truncate to their own width.
  function automatic logic [63:0] byte_merge(input logic [63:0] old_word,
                                             input logic [63:0] new_word,
                                             input logic [7:0]  strb);
    logic [63:0] merged;
    merged = old_word;
    for (int b = 0; b < 8; b++) begin
      if (strb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axi_lite_wr_buffer.sv
// One valid/ready hold register: accepts a beat when ready, holds it until
// the consumer clears it.
module axi_lite_wr_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         valid,
  input  logic [W-1:0] data,
  input  logic         clr,
  output logic         ready,
  output logic         hold,
  output logic [W-1:0] q
);

  // A beat transfers on a rising edge where valid & ready are both high;
  // ready never depends on valid, and the holder keeps its beat until clr.
  assign ready = en & ~hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= 1'b0;
      q    <= '0;
    end else if (clr) begin
      hold <= 1'b0;
    end else if (valid && ready) begin
      hold <= 1'b1;
      q    <= data;
    end
  end

endmodule

// File: rtl/s_axi_lite_regfile.sv
// AXI4-Lite slave register file: buffered AW/W, byte strobes, SLVERR on
// out-of-range words, flat register export and per-register write pulses.
module s_axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter int P_S_AXI_DATA_WIDTH = 32,
  parameter int P_S_AXI_ADDR_WIDTH = 6,
  parameter int P_REG_NUM          = 16
) (
  input  logic                                    S_AXI_ACLK,
  input  logic                                    S_AXI_ARESETN,
  input  logic [P_S_AXI_ADDR_WIDTH-1:0]           S_AXI_AWADDR,
  input  logic [2:0]                              S_AXI_AWPROT,
  input  logic                                    S_AXI_AWVALID,
  output logic                                    S_AXI_AWREADY,
  input  logic [P_S_AXI_DATA_WIDTH-1:0]           S_AXI_WDATA,
  input  logic [P_S_AXI_DATA_WIDTH/8-1:0]         S_AXI_WSTRB,
  input  logic                                    S_AXI_WVALID,
  output logic                                    S_AXI_WREADY,
  output logic [1:0]                              S_AXI_BRESP,
  output logic                                    S_AXI_BVALID,
  input  logic                                    S_AXI_BREADY,
  input  logic [P_S_AXI_ADDR_WIDTH-1:0]           S_AXI_ARADDR,
  input  logic [2:0]                              S_AXI_ARPROT,
  input  logic                                    S_AXI_ARVALID,
  output logic                                    S_AXI_ARREADY,
  output logic [P_S_AXI_DATA_WIDTH-1:0]           S_AXI_RDATA,
  output logic [1:0]                              S_AXI_RRESP,
  output logic                                    S_AXI_RVALID,
  input  logic                                    S_AXI_RREADY,
  output logic [P_REG_NUM*P_S_AXI_DATA_WIDTH-1:0] o_regs,
  output logic [P_REG_NUM-1:0]                    o_wr_pulse
);

  localparam int DW       = P_S_AXI_DATA_WIDTH;
  localparam int SW       = DW / 8;
  localparam int ADDR_LSB = addr_lsb(DW);
  localparam int IDX_W    = P_S_AXI_ADDR_WIDTH - ADDR_LSB;

  logic              r_init_done;
  logic [DW-1:0]     regs [P_REG_NUM];
  logic              aw_hold, w_hold, commit, aw_in_range, ar_in_range;
  logic [IDX_W-1:0]  aw_idx, ar_idx;
  logic [DW-1:0]     w_data, rd_word;
  logic [SW-1:0]     w_strb;
  logic              wr_en;

  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) r_init_done <= 1'b0;
    else                r_init_done <= 1'b1;
  end

  // Both buffers stall while a write response is pending: one write in flight.
  assign wr_en  = r_init_done & ~S_AXI_BVALID;
  assign commit = aw_hold & w_hold & ~S_AXI_BVALID;

  axi_lite_wr_buffer #(.W(IDX_W)) u_aw_buf (
    .clk   (S_AXI_ACLK),
    .rst_n (S_AXI_ARESETN),
    .en    (wr_en),
    .valid (S_AXI_AWVALID),
    .data  (S_AXI_AWADDR[P_S_AXI_ADDR_WIDTH-1:ADDR_LSB]),
    .clr   (commit),
    .ready (S_AXI_AWREADY),
    .hold  (aw_hold),
    .q     (aw_idx)
  );

  axi_lite_wr_buffer #(.W(DW + SW)) u_w_buf (
    .clk   (S_AXI_ACLK),
    .rst_n (S_AXI_ARESETN),
    .en    (wr_en),
    .valid (S_AXI_WVALID),
    .data  ({S_AXI_WDATA, S_AXI_WSTRB}),
    .clr   (commit),
    .ready (S_AXI_WREADY),
    .hold  (w_hold),
    .q     ({w_data, w_strb})
  );

  assign aw_in_range = int'(aw_idx) < P_REG_NUM;
  assign ar_idx      = S_AXI_ARADDR[P_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
  assign ar_in_range = int'(ar_idx) < P_REG_NUM;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int k = 0; k < P_REG_NUM; k++) regs[k] <= '0;
      o_wr_pulse   <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= RESP_OKAY;
    end else begin
      o_wr_pulse <= '0;
      if (commit) begin
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
        for (int k = 0; k < P_REG_NUM; k++) begin
          if (aw_in_range && aw_idx == IDX_W'(k)) begin
            regs[k]       <= DW'(byte_merge(64'(regs[k]), 64'(w_data), 8'(w_strb)));
            o_wr_pulse[k] <= 1'b1;
          end
        end
      end else if (S_AXI_BVALID && S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < P_REG_NUM; k++) begin
      if (ar_idx == IDX_W'(k)) rd_word = regs[k];
    end
  end

  assign S_AXI_ARREADY = r_init_done & ~S_AXI_RVALID;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
      S_AXI_RRESP  <= RESP_OKAY;
    end else if (S_AXI_ARVALID && S_AXI_ARREADY) begin
      S_AXI_RVALID <= 1'b1;
      S_AXI_RDATA  <= ar_in_range ? rd_word : '0;
      S_AXI_RRESP  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (S_AXI_RVALID && S_AXI_RREADY) begin
      S_AXI_RVALID <= 1'b0;
    end
  end

  always_comb begin
    for (int k = 0; k < P_REG_NUM; k++) o_regs[k*DW +: DW] = regs[k];
  end

endmodule
